// File: rtl/intctl.sv
// ---------------------------------------------------------------------------
// intctl - four-source edge-triggered interrupt controller
//
// Memory-mapped register window (selected externally) holding a pending
// latch per source, a mask register, a priority-resolved CAUSE register and
// a write-1-to-clear ACK register.  A three-state FSM (IDLE/REQ/SERVICE)
// raises a registered interrupt request towards the CPU, drops it when the
// CPU reads CAUSE, and holds off further requests until the in-service
// source has been acknowledged.
//
// Ports
//   clk      in   1   system clock, rising edge
//   rst_n    in   1   asynchronous active-low reset
//   sel      in   1   register window select
//   addr     in   4   byte offset inside the window ([1:0] ignored)
//   we       in   1   write strobe (qualified by sel)
//   re       in   1   read strobe (qualified by sel), CAUSE side effect only
//   wdata    in  32   write data
//   rdata    out 32   combinational read data of the addressed register
//   irq_src  in   4   synchronous level interrupt sources
//   intrq    out  1   registered interrupt request
//
// Register map (addr[3:2])
//   0 PEND  RO  [3:0] pending
//   1 MASK  RW  [3:0] mask
//   2 CAUSE RO  [31] valid, [1:0] id of lowest pending&mask source
//   3 ACK   WO  write 1 to clear the pending bit
// ---------------------------------------------------------------------------
module intctl #(
  parameter int NSRC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic [3:0]       addr,
  input  logic             we,
  input  logic             re,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [NSRC-1:0]  irq_src,
  output logic             intrq
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] REG_PEND  = 2'd0;
  localparam logic [1:0] REG_MASK  = 2'd1;
  localparam logic [1:0] REG_CAUSE = 2'd2;
  localparam logic [1:0] REG_ACK   = 2'd3;

  // Lowest-index set bit wins; result is {valid, id}.
  function automatic logic [2:0] pick_winner(input logic [NSRC-1:0] req);
    logic [2:0] res;
    res = 3'b000;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        res = {1'b1, i[1:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // State
  logic [NSRC-1:0] pending_r;
  logic [NSRC-1:0] mask_r;
  logic [NSRC-1:0] prev_r;
  logic            armed_r;
  state_t          state_r;
  logic [1:0]      insvc_r;
  logic            intrq_r;

  // Combinational helpers
  logic            mask_wr_s;
  logic            ack_wr_s;
  logic            cause_rd_s;
  logic [NSRC-1:0] set_s;
  logic [NSRC-1:0] clr_s;
  logic [NSRC-1:0] pending_next_s;
  logic [NSRC-1:0] active_vec_s;
  logic            active_s;
  logic [2:0]      winner_s;
  logic            win_valid_s;
  logic [1:0]      win_id_s;
  state_t          state_next_s;
  logic            intrq_next_s;
  logic            unused_s;

  assign mask_wr_s    = sel & we & (addr[3:2] == REG_MASK);
  assign ack_wr_s     = sel & we & (addr[3:2] == REG_ACK);
  assign cause_rd_s   = sel & re & (addr[3:2] == REG_CAUSE);
  assign active_vec_s = pending_r & mask_r;
  assign active_s     = |active_vec_s;
  assign winner_s     = pick_winner(active_vec_s);
  assign win_valid_s  = winner_s[2];
  assign win_id_s     = winner_s[1:0];
  assign intrq        = intrq_r;
  assign unused_s     = ^{addr[1:0], wdata[31:NSRC]};

  // Pending update: rising-edge set beats ACK clear on the same bit.
  // armed_r stays low for the first edge after reset so that a source
  // already high at reset release is not taken as a new edge.
  always_comb begin
    set_s          = '0;
    clr_s          = '0;
    pending_next_s = pending_r;
    if (armed_r) begin
      set_s = irq_src & ~prev_r;
    end else begin
      set_s = '0;
    end
    if (ack_wr_s) begin
      clr_s = wdata[NSRC-1:0];
    end else begin
      clr_s = '0;
    end
    pending_next_s = (pending_r & ~clr_s) | set_s;
  end

  // Source edge detector, pending latch and mask register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r    <= '0;
      armed_r   <= 1'b0;
      pending_r <= '0;
      mask_r    <= '0;
    end else begin
      prev_r    <= irq_src;
      armed_r   <= 1'b1;
      pending_r <= pending_next_s;
      if (mask_wr_s) begin
        mask_r <= wdata[NSRC-1:0];
      end else begin
        mask_r <= mask_r;
      end
    end
  end

  // FSM state register; captures the winner id on entry to SERVICE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      insvc_r <= 2'd0;
    end else begin
      state_r <= state_next_s;
      if ((state_r == ST_REQ) && (state_next_s == ST_SERVICE)) begin
        insvc_r <= win_id_s;
      end else begin
        insvc_r <= insvc_r;
      end
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (active_s) begin
          state_next_s = ST_REQ;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        // Losing every request (mask or ACK) wins over a coincident read.
        if (!active_s) begin
          state_next_s = ST_IDLE;
        end else if (cause_rd_s) begin
          state_next_s = ST_SERVICE;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_SERVICE: begin
        if (!pending_r[insvc_r]) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_SERVICE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM output logic: request is high exactly while the FSM sits in REQ.
  always_comb begin
    intrq_next_s = 1'b0;
    if (state_next_s == ST_REQ) begin
      intrq_next_s = 1'b1;
    end else begin
      intrq_next_s = 1'b0;
    end
  end

  // Registered interrupt request output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      intrq_r <= 1'b0;
    end else begin
      intrq_r <= intrq_next_s;
    end
  end

  // Read data mux; unused bits and the ACK address read as zero.
  always_comb begin
    rdata = 32'd0;
    case (addr[3:2])
      REG_PEND:  rdata = {{(32-NSRC){1'b0}}, pending_r};
      REG_MASK:  rdata = {{(32-NSRC){1'b0}}, mask_r};
      REG_CAUSE: rdata = {win_valid_s, 29'd0, win_id_s};
      REG_ACK:   rdata = 32'd0;
      default:   rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_intctl.sv
// ---------------------------------------------------------------------------
// tb_intctl - directed, table-driven self-checking bench for intctl.
// Each vector is driven on the falling edge and checked 1 time unit later,
// so rdata/intrq reflect state left by the previous rising edges combined
// with the vector's own inputs; the following rising edge consumes it.
// ---------------------------------------------------------------------------
module tb_intctl;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic [3:0]  addr;
  logic        we;
  logic        re;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  irq_src;
  logic        intrq;

  int total;
  int bad;

  intctl #(.NSRC(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sel     (sel),
    .addr    (addr),
    .we      (we),
    .re      (re),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq_src (irq_src),
    .intrq   (intrq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        re;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  src;
    logic [31:0] exp_rdata;
    logic        exp_intrq;
  } vec_t;

  localparam int NVEC = 41;
  vec_t tbl[NVEC];

  function automatic vec_t mk(input logic w, input logic r, input logic [3:0] a,
                              input logic [31:0] d, input logic [3:0] s,
                              input logic [31:0] er, input logic ei);
    vec_t v;
    v.we = w; v.re = r; v.addr = a; v.wdata = d; v.src = s;
    v.exp_rdata = er; v.exp_intrq = ei;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic step(input string name, input logic w, input logic r,
                      input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [31:0] er, input logic ei);
    @(negedge clk);
    sel = 1'b1; we = w; re = r; addr = a; wdata = d; irq_src = s;
    #1;
    chk({name, " rdata"}, rdata, er);
    chk({name, " intrq"}, {31'd0, intrq}, {31'd0, ei});
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; sel = 1'b0; we = 1'b0; re = 1'b0;
    addr = 4'h0; wdata = 32'd0; irq_src = 4'h0;

    // Basic single source: request, CAUSE read, ACK.
    tbl[0]  = mk(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    tbl[1]  = mk(1'b1, 1'b0, 4'h4, 32'h1, 4'h0, 32'h0, 1'b0);
    tbl[2]  = mk(1'b0, 1'b0, 4'h0, 32'h0, 4'h1, 32'h0, 1'b0);
    tbl[3]  = mk(1'b0, 1'b0, 4'h0, 32'h0, 4'h1, 32'h1, 1'b0);
    tbl[4]  = mk(1'b0, 1'b1, 4'h8, 32'h0, 4'h1, 32'h80000000, 1'b1);
    tbl[5]  = mk(1'b0, 1'b0, 4'h0, 32'h0, 4'h1, 32'h1, 1'b0);
    tbl[6]  = mk(1'b1, 1'b0, 4'hC, 32'h1, 4'h1, 32'h0, 1'b0);
    tbl[7]  = mk(1'b0, 1'b0, 4'h0, 32'h0, 4'h1, 32'h0, 1'b0);
    tbl[8]  = mk(1'b0, 1'b0, 4'h8, 32'h0, 4'h0, 32'h0, 1'b0);
    // Masked source, late unmask, then mask away while in REQ.
    tbl[9]  = mk(1'b1, 1'b0, 4'h4, 32'h0, 4'h0, 32'h1, 1'b0);
    tbl[10] = mk(1'b0, 1'b0, 4'h0, 32'h0, 4'h2, 32'h0, 1'b0);
    tbl[11] = mk(1'b0, 1'b0, 4'h0, 32'h0, 4'h2, 32'h2, 1'b0);
    tbl[12] = mk(1'b0, 1'b0, 4'h0, 32'h0, 4'h2, 32'h2, 1'b0);
    tbl[13] = mk(1'b1, 1'b0, 4'h4, 32'h2, 4'h2, 32'h0, 1'b0);
    tbl[14] = mk(1'b0, 1'b0, 4'h4, 32'h0, 4'h2, 32'h2, 1'b0);
    tbl[15] = mk(1'b0, 1'b0, 4'h0, 32'h0, 4'h2, 32'h2, 1'b1);
    tbl[16] = mk(1'b1, 1'b0, 4'h4, 32'h0, 4'h2, 32'h2, 1'b1);
    tbl[17] = mk(1'b0, 1'b0, 4'h8, 32'h0, 4'h2, 32'h0, 1'b1);
    tbl[18] = mk(1'b0, 1'b0, 4'h0, 32'h0, 4'h2, 32'h2, 1'b0);
    tbl[19] = mk(1'b1, 1'b0, 4'hC, 32'h2, 4'h2, 32'h0, 1'b0);
    tbl[20] = mk(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    // Two simultaneous sources: priority, ACK, re-request of the other.
    tbl[21] = mk(1'b1, 1'b0, 4'h4, 32'hF, 4'h0, 32'h0, 1'b0);
    tbl[22] = mk(1'b0, 1'b0, 4'h0, 32'h0, 4'hC, 32'h0, 1'b0);
    tbl[23] = mk(1'b0, 1'b0, 4'h0, 32'h0, 4'hC, 32'hC, 1'b0);
    tbl[24] = mk(1'b0, 1'b1, 4'h8, 32'h0, 4'hC, 32'h80000002, 1'b1);
    tbl[25] = mk(1'b1, 1'b0, 4'hC, 32'h4, 4'hC, 32'h0, 1'b0);
    tbl[26] = mk(1'b0, 1'b0, 4'h8, 32'h0, 4'hC, 32'h80000003, 1'b0);
    tbl[27] = mk(1'b0, 1'b0, 4'h0, 32'h0, 4'hC, 32'h8, 1'b0);
    tbl[28] = mk(1'b0, 1'b1, 4'h8, 32'h0, 4'hC, 32'h80000003, 1'b1);
    tbl[29] = mk(1'b1, 1'b0, 4'hC, 32'h8, 4'h0, 32'h0, 1'b0);
    tbl[30] = mk(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    tbl[31] = mk(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    // In SERVICE id=0: ACK coincident with a new src0 edge.
    tbl[32] = mk(1'b0, 1'b0, 4'h0, 32'h0, 4'h1, 32'h0, 1'b0);
    tbl[33] = mk(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 32'h1, 1'b0);
    tbl[34] = mk(1'b0, 1'b1, 4'h8, 32'h0, 4'h0, 32'h80000000, 1'b1);
    tbl[35] = mk(1'b1, 1'b0, 4'hC, 32'h1, 4'h1, 32'h0, 1'b0);
    tbl[36] = mk(1'b0, 1'b0, 4'h0, 32'h0, 4'h1, 32'h1, 1'b0);
    tbl[37] = mk(1'b0, 1'b0, 4'h0, 32'h0, 4'h1, 32'h1, 1'b0);
    tbl[38] = mk(1'b1, 1'b0, 4'hC, 32'h1, 4'h1, 32'h0, 1'b0);
    tbl[39] = mk(1'b0, 1'b0, 4'h0, 32'h0, 4'h1, 32'h0, 1'b0);
    tbl[40] = mk(1'b0, 1'b0, 4'h0, 32'h0, 4'h1, 32'h0, 1'b0);

    // Reset state while rst_n is low.
    repeat (2) @(negedge clk);
    sel = 1'b1; addr = 4'h0; #1; chk("reset PEND", rdata, 32'h0);
    addr = 4'h4; #1; chk("reset MASK", rdata, 32'h0);
    addr = 4'h8; #1; chk("reset CAUSE", rdata, 32'h0);
    chk("reset intrq", {31'd0, intrq}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      step($sformatf("vec%0d", i), tbl[i].we, tbl[i].re, tbl[i].addr,
           tbl[i].wdata, tbl[i].src, tbl[i].exp_rdata, tbl[i].exp_intrq);
    end

    // Source 1 held high for 20 cycles: only one pending set.
    for (int i = 0; i < 20; i++) begin
      step($sformatf("hold%0d", i), 1'b0, 1'b0, 4'h0, 32'h0, 4'h2,
           (i == 0) ? 32'h0 : 32'h2, (i >= 2) ? 1'b1 : 1'b0);
    end
    step("hold cause", 1'b0, 1'b1, 4'h8, 32'h0, 4'h2, 32'h80000001, 1'b1);
    step("hold ack",   1'b1, 1'b0, 4'hC, 32'h2, 4'h2, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step($sformatf("hold post%0d", i), 1'b0, 1'b0, 4'h0, 32'h0, 4'h2, 32'h0, 1'b0);
    end

    // Reach REQ, then reset asynchronously mid-cycle.
    step("pre rst a", 1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    step("pre rst b", 1'b0, 1'b0, 4'h0, 32'h0, 4'h1, 32'h0, 1'b0);
    step("pre rst c", 1'b0, 1'b0, 4'h0, 32'h0, 4'h1, 32'h1, 1'b0);
    step("pre rst d", 1'b0, 1'b0, 4'h0, 32'h0, 4'h1, 32'h1, 1'b1);
    @(negedge clk);
    we = 1'b0; re = 1'b0; addr = 4'h0;
    #1 rst_n = 1'b0;
    #1;
    chk("async rst intrq", {31'd0, intrq}, 32'h0);
    chk("async rst PEND", rdata, 32'h0);
    addr = 4'h4; #1;
    chk("async rst MASK", rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Source high across reset release must not register as an edge.
    step("post rst mask", 1'b1, 1'b0, 4'h4, 32'hF, 4'h1, 32'h0, 1'b0);
    step("post rst a",    1'b0, 1'b0, 4'h0, 32'h0, 4'h1, 32'h0, 1'b0);
    step("post rst b",    1'b0, 1'b0, 4'h0, 32'h0, 4'h1, 32'h0, 1'b0);
    step("post rst c",    1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    step("post rst d",    1'b0, 1'b0, 4'h0, 32'h0, 4'h1, 32'h0, 1'b0);
    step("post rst e",    1'b0, 1'b0, 4'h0, 32'h0, 4'h1, 32'h1, 1'b0);
    step("post rst f",    1'b0, 1'b0, 4'h0, 32'h0, 4'h1, 32'h1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
